// File: rtl/pipeline_stall_ctrl.sv
// pipeline_stall_ctrl: stall/flush sequencer for the 5-stage pipeline.
// It merges load-use bubbles, multiply occupancy, branch flushes and
// data-memory waits into the PC, IF_ID, ID_EX and EX controls.
// Optional macro STALL_STATS_EN builds the stall_cnt_o and flush_cnt_o
// statistics counters. Without it, both outputs are tied to 0.
// Ports:
//   clk_i, rst_i (async, active-low)
//   inputs:  load_use_i, mul_start_i, flush_i, mem_stall_i
//   outputs: pc_write_o, if_id_write_o, if_id_flush_o, id_ex_bubble_o,
//            ex_hold_o, mul_done_o, state_o[1:0]
//   outputs: stall_cnt_o[31:0], flush_cnt_o[31:0]
module pipeline_stall_ctrl #(
  parameter int MUL_LAT   = 4,
  parameter int FLUSH_LAT = 1,
  parameter int CNT_W     = 3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        load_use_i,
  input  logic        mul_start_i,
  input  logic        flush_i,
  input  logic        mem_stall_i,
  output logic        pc_write_o,
  output logic        if_id_write_o,
  output logic        if_id_flush_o,
  output logic        id_ex_bubble_o,
  output logic        ex_hold_o,
  output logic        mul_done_o,
  output logic [1:0]  state_o,
  output logic [31:0] stall_cnt_o,
  output logic [31:0] flush_cnt_o
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MUL_WAIT = 2'd1,
    FLUSH    = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             cnt_zero;

  assign cnt_zero = (cnt_q == '0);
  assign state_o  = state_q;

  always_comb begin
    pc_write_o     = 1'b1;
    if_id_write_o  = 1'b1;
    if_id_flush_o  = 1'b0;
    id_ex_bubble_o = 1'b0;
    ex_hold_o      = 1'b0;
    mul_done_o     = 1'b0;
    state_d        = state_q;
    cnt_d          = cnt_q;
    if (!rst_i) begin
      state_d = RUN;
      cnt_d   = '0;
    end else if (mem_stall_i) begin
      // Everything freezes; the sequencer resumes where it left off.
      pc_write_o    = 1'b0;
      if_id_write_o = 1'b0;
      ex_hold_o     = 1'b1;
    end else begin
      case (state_q)
        RUN: begin
          if (mul_start_i) begin
            pc_write_o    = 1'b0;
            if_id_write_o = 1'b0;
            ex_hold_o     = 1'b1;
            cnt_d         = CNT_W'(MUL_LAT - 2);
            state_d       = MUL_WAIT;
          end else if (flush_i) begin
            if_id_flush_o  = 1'b1;
            id_ex_bubble_o = 1'b1;
            if (FLUSH_LAT > 1) begin
              cnt_d   = CNT_W'(FLUSH_LAT - 2);
              state_d = FLUSH;
            end
          end else if (load_use_i) begin
            pc_write_o     = 1'b0;
            if_id_write_o  = 1'b0;
            id_ex_bubble_o = 1'b1;
          end
        end
        MUL_WAIT: begin
          // ID stays frozen, so flush and load-use are re-seen in RUN.
          pc_write_o    = 1'b0;
          if_id_write_o = 1'b0;
          if (!cnt_zero) begin
            ex_hold_o = 1'b1;
            cnt_d     = cnt_q - CNT_W'(1);
          end else begin
            mul_done_o = 1'b1;
            state_d    = RUN;
          end
        end
        FLUSH: begin
          if_id_flush_o  = 1'b1;
          id_ex_bubble_o = 1'b1;
          if (!cnt_zero) begin
            cnt_d = cnt_q - CNT_W'(1);
          end else begin
            state_d = RUN;
          end
        end
        default: begin
          state_d = RUN;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef STALL_STATS_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] flush_cnt_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (!pc_write_o)
        stall_cnt_q <= stall_cnt_q + 32'd1;
      if (if_id_flush_o)
        flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`else
  assign stall_cnt_o = '0;
  assign flush_cnt_o = '0;
`endif

endmodule
